// File: rtl/parking_sensor_emulator.sv
// Transmitter for the two-photosensor car-passage protocol: plays back the
// four-phase a/b pattern for enter/exit commands and tracks occupancy.
module parking_sensor_emulator #(
    parameter int CAP = 15,
    parameter int PHASE_W = 8,
    localparam int OCC_W = $clog2(CAP + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    input  logic               req_dir,
    output logic               req_ready,
    input  logic [PHASE_W-1:0] phase_len,
    input  logic               abort,
    output logic               a,
    output logic               b,
    output logic               busy,
    output logic               done,
    output logic               rej,
    output logic [OCC_W-1:0]   occupancy
);

    typedef enum logic [2:0] {IDLE, PH1, PH2, PH3, GAP} state_t;

    state_t             state, state_n;
    logic [PHASE_W-1:0] cnt, cnt_n;
    logic [PHASE_W-1:0] len, len_n;
    logic               dir, dir_n;
    logic               a_n, b_n, busy_n, done_n, rej_n;
    logic [OCC_W-1:0]   occ_n;
    logic [PHASE_W-1:0] len_eff;
    logic               last;

    assign len_eff   = (phase_len == '0) ? PHASE_W'(1) : phase_len;
    assign last      = (cnt == PHASE_W'(1));
    assign req_ready = (state == IDLE);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        len_n   = len;
        dir_n   = dir;
        a_n     = a;
        b_n     = b;
        busy_n  = busy;
        done_n  = 1'b0;
        rej_n   = 1'b0;
        occ_n   = occupancy;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if ((!req_dir && occupancy == OCC_W'(CAP)) ||
                        ( req_dir && occupancy == '0)) begin
                        rej_n = 1'b1;
                    end else begin
                        state_n = PH1;
                        cnt_n   = len_eff;
                        len_n   = len_eff;
                        dir_n   = req_dir;
                        a_n     = ~req_dir;
                        b_n     = req_dir;
                        busy_n  = 1'b1;
                    end
                end
            end
            default: begin
                // abort wins over a phase advance landing in the same cycle
                if (abort) begin
                    state_n = IDLE;
                    a_n     = 1'b0;
                    b_n     = 1'b0;
                    busy_n  = 1'b0;
                end else if (!last) begin
                    cnt_n = cnt - PHASE_W'(1);
                end else begin
                    cnt_n = len;
                    case (state)
                        PH1: begin
                            state_n = PH2;
                            a_n     = 1'b1;
                            b_n     = 1'b1;
                        end
                        PH2: begin
                            state_n = PH3;
                            a_n     = dir;
                            b_n     = ~dir;
                        end
                        PH3: begin
                            state_n = GAP;
                            a_n     = 1'b0;
                            b_n     = 1'b0;
                        end
                        default: begin
                            state_n = IDLE;
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                            occ_n   = dir ? occupancy - OCC_W'(1)
                                          : occupancy + OCC_W'(1);
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            len       <= '0;
            dir       <= 1'b0;
            a         <= 1'b0;
            b         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rej       <= 1'b0;
            occupancy <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            len       <= len_n;
            dir       <= dir_n;
            a         <= a_n;
            b         <= b_n;
            busy      <= busy_n;
            done      <= done_n;
            rej       <= rej_n;
            occupancy <= occ_n;
        end
    end

endmodule

// File: tb/tb_parking_sensor_emulator.sv
// Self-checking bench: directed test-plan sequences plus random traffic,
// compared each cycle against a position-in-sequence arithmetic model.
module tb_parking_sensor_emulator;

    localparam int CAP   = 2;
    localparam int OCC_W = $clog2(CAP + 1);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_dir = 1'b0;
    logic             req_ready;
    logic [7:0]       phase_len = '0;
    logic             abort = 1'b0;
    logic             a, b, busy, done, rej;
    logic [OCC_W-1:0] occupancy;

    int n_cmp = 0;
    int n_bad = 0;

    // model: an active sequence is described by acceptance cycle, length, direction
    bit m_act = 0;
    int m_acc = 0;
    int m_len = 1;
    bit m_dir = 0;
    int m_occ = 0;
    bit m_done = 0;
    bit m_rej = 0;
    int cyc = 0;

    parking_sensor_emulator #(.CAP(CAP), .PHASE_W(8)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_dir(req_dir),
        .req_ready(req_ready), .phase_len(phase_len), .abort(abort),
        .a(a), .b(b), .busy(busy), .done(done), .rej(rej), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic check_outputs();
        int k, p, ea, eb;
        ea = 0;
        eb = 0;
        if (m_act) begin
            k = cyc - m_acc;
            p = (k - 1) / m_len;
            case (p)
                0: begin ea = m_dir ? 0 : 1; eb = m_dir ? 1 : 0; end
                1: begin ea = 1; eb = 1; end
                2: begin ea = m_dir ? 1 : 0; eb = m_dir ? 0 : 1; end
                default: begin ea = 0; eb = 0; end
            endcase
        end
        check("a", int'(a), ea);
        check("b", int'(b), eb);
        check("busy", int'(busy), int'(m_act));
        check("done", int'(done), int'(m_done));
        check("rej", int'(rej), int'(m_rej));
        check("occupancy", int'(occupancy), m_occ);
        check("req_ready", int'(req_ready), m_act ? 0 : 1);
    endtask

    task automatic model_edge(input bit v, input bit d, input int len, input bit ab);
        int k;
        m_done = 0;
        m_rej  = 0;
        if (m_act) begin
            k = cyc + 1 - m_acc;
            if (ab) begin
                m_act = 0;
            end else if (k == 4 * m_len + 1) begin
                m_act  = 0;
                m_done = 1;
                m_occ  = m_dir ? m_occ - 1 : m_occ + 1;
            end
        end else if (v) begin
            if ((!d && m_occ == CAP) || (d && m_occ == 0)) begin
                m_rej = 1;
            end else begin
                m_act = 1;
                m_acc = cyc;
                m_len = (len == 0) ? 1 : len;
                m_dir = d;
            end
        end
        cyc++;
    endtask

    // called at a falling edge: check, drive, advance one cycle
    task automatic step(input bit v, input bit d, input int len, input bit ab);
        check_outputs();
        req_valid = v;
        req_dir   = d;
        phase_len = 8'(len);
        abort     = ab;
        @(posedge clk);
        model_edge(v, d, len, ab);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, $urandom_range(0, 5), 0);
    endtask

    task automatic pulse_reset();
        req_valid = 0;
        abort     = 0;
        #2;
        reset = 1;
        #1;
        check("rst_a", int'(a), 0);
        check("rst_b", int'(b), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_occ", int'(occupancy), 0);
        check("rst_done", int'(done), 0);
        check("rst_rej", int'(rej), 0);
        check("rst_ready", int'(req_ready), 1);
        @(posedge clk);
        @(negedge clk);
        reset  = 0;
        m_act  = 0;
        m_occ  = 0;
        m_done = 0;
        m_rej  = 0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 0;

        step(1, 0, 2, 0); idle(9);                    // enter L=2
        step(1, 1, 3, 0); idle(13);                   // exit L=3
        step(1, 1, 1, 0); idle(2);                    // exit at 0 -> refused
        step(1, 0, 0, 0); idle(4);                    // L=0 acts as 1
        step(1, 0, 0, 0); idle(5);                    // accepted in done cycle
        step(1, 0, 1, 0); idle(2);                    // full -> refused
        step(1, 1, 1, 0); idle(5);                    // back to 1
        step(1, 0, 2, 0); idle(2); step(0, 0, 2, 1); idle(4);  // abort in PH2
        step(1, 0, 2, 0); idle(5); pulse_reset();     // reset in PH3
        step(1, 0, 2, 0); idle(10);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                pulse_reset();
            end else begin
                step($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                     $urandom_range(0, 3), $urandom_range(0, 40) == 0);
            end
        end
        check_outputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/parking_sensor_emulator.md
Name: parking_sensor_emulator

Overview:
- Transmitter side of the two-photosensor car-passage protocol.
- Accepts enter/exit commands over a valid/ready handshake and drives the sensor lines a and b through the four-phase pattern that the occupancy decoder recognises.
- Maintains its own occupancy count bounded by a capacity limit, and refuses commands that would overflow or underflow it.
- Used as a bench/board stimulus source in front of the parking occupancy counter.

Parameters:
- CAP, 15, maximum occupancy; enter commands refused when occupancy == CAP.
- PHASE_W, 8, width of phase_len.
- OCC_W, $clog2(CAP+1), width of occupancy (derived; do not override).

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- req_valid  in  1  command valid
- req_dir  in  1  command direction; 0 = enter, 1 = exit
- req_ready  out  1  high when a command can be accepted (IDLE)
- phase_len  in  PHASE_W  cycles per phase, sampled on acceptance; 0 treated as 1
- abort  in  1  synchronous abort of an in-flight sequence
- a  out  1  sensor a (registered)
- b  out  1  sensor b (registered)
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse: sequence completed
- rej  out  1  one-cycle pulse: command refused
- occupancy  out  OCC_W  cars currently inside

Behaviour:
- Reset values: a=0, b=0, busy=0, done=0, rej=0, occupancy=0, state IDLE, req_ready=1.
- All outputs except req_ready are registered. req_ready = (state == IDLE) combinationally.
- States: IDLE, PH1, PH2, PH3, GAP. A down-counter loaded with L = max(phase_len,1) on acceptance and on each phase change.
- Accept at cycle t0, when req_valid & req_ready:
  - Enter with occupancy == CAP, or exit with occupancy == 0: rej=1 at t0+1, state stays IDLE, a/b unchanged.
  - Otherwise move to PH1.
- Phase timing for an accepted command:
  - PH1 drives a/b during cycles t0+1..t0+L.
  - PH2 drives t0+L+1..t0+2L.
  - PH3 drives t0+2L+1..t0+3L.
  - GAP drives t0+3L+1..t0+4L.
- Waveforms (a,b):
  - Enter: PH1 (1,0), PH2 (1,1), PH3 (0,1), GAP (0,0).
  - Exit: PH1 (0,1), PH2 (1,1), PH3 (1,0), GAP (0,0).
- GAP must last at least 1 cycle so the decoder returns to its idle state before the next car.
- busy=1 exactly during cycles t0+1..t0+4L.
- Completion at t0+4L+1:
  - done=1 for one cycle.
  - occupancy is incremented (enter) or decremented (exit); the new value is visible that same cycle.
  - State is IDLE, so req_ready=1 and a new command may be accepted that cycle.
- Back-to-back commands: accepting at t0+4L+1 starts the next PH1 at t0+4L+2. No idle gap beyond GAP is required.
- phase_len changes while busy are ignored. Only the value sampled at acceptance is used.
- abort while busy:
  - Next cycle: a=b=0, busy=0, state IDLE.
  - No done pulse, occupancy unchanged.
  - abort in IDLE is ignored. abort has priority over phase advance in the same cycle.
- req_valid while busy is ignored: not latched, not queued.
- req_dir is sampled only at acceptance.
- occupancy never wraps. The refusal rule guarantees 0 <= occupancy <= CAP.
- Asynchronous reset mid-sequence returns all outputs to their reset values immediately. No done and no rej are issued.
- At most one of done and rej is high in any cycle.

Test Plan:
- CAP=2, phase_len=2; enter accepted at t0 -> a,b = 10,10,11,11,01,01,00,00 over t0+1..t0+8; busy high over the same cycles; done=1 and occupancy=1 at t0+9.
- From occupancy=1, exit with phase_len=3 -> a,b = 01×3, 11×3, 10×3, 00×3; done at t0+13; occupancy=0.
- Occupancy=0, exit request -> rej=1 at t0+1, a=b=0, busy=0, occupancy=0. Then two enters with CAP=2 reach occupancy=2; a third enter -> rej=1, occupancy stays 2.
- phase_len=0 -> each phase lasts 1 cycle; done at t0+5. Back-to-back enter accepted in the done cycle starts PH1 (a=1,b=0) the following cycle.
- abort asserted during PH2 of an enter -> next cycle a=b=0, busy=0, req_ready=1; no done pulse; occupancy unchanged.
- reset asserted asynchronously during PH3 -> a=b=0, occupancy=0, busy=0 immediately; after release, a new enter completes normally with occupancy=1.
